pool2: RTL and testbench



---
 rtl/cnn_pkg.sv | 25 ++
 rtl/max4_pipe.sv | 45 ++++
 rtl/pool2.sv | 161 ++++++++++++++++
 tb/tb_pool2.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants, pooling FSM state type and signed max helper for the CNN
// datapath stages.
package cnn_pkg;

  localparam int C2_CH  = 32;
  localparam int C2_DIM = 14;
  localparam int P2_DIM = 7;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE,
    WAIT_START_LOW
  } pool_state_t;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/max4_pipe.sv
// Two-stage signed max tree over one 2x2 window. Stage 1 registers the two
// row maxima plus index/valid sideband; stage 2 is the final compare.
module max4_pipe
  import cnn_pkg::*;
#(
  parameter int IDX_W = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic [IDX_W-1:0]         issue_idx,
  input  logic signed [DATA_W-1:0] px00,
  input  logic signed [DATA_W-1:0] px01,
  input  logic signed [DATA_W-1:0] px10,
  input  logic signed [DATA_W-1:0] px11,
  output logic                     res_valid,
  output logic [IDX_W-1:0]         res_idx,
  output logic signed [DATA_W-1:0] res_max
);

  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] b;
  logic                     s1_valid;
  logic [IDX_W-1:0]         s1_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      a        <= '0;
      b        <= '0;
    end else begin
      s1_valid <= issue_valid;
      s1_idx   <= issue_idx;
      a        <= smax(px00, px01);
      b        <= smax(px10, px11);
    end
  end

  // The result register lives in the consumer, so stage 2 is the bare compare.
  assign res_valid = s1_valid;
  assign res_idx   = s1_idx;
  assign res_max   = smax(a, b);

endmodule

// File: rtl/pool2.sv
// 2x2/stride-2 signed max-pooling stage with start/done level handshake.
// Optional result stream (out_valid/out_data/out_idx) under POOL2_STREAM_EN.
module pool2
  import cnn_pkg::*;
#(
  parameter int CH      = C2_CH,
  parameter int IN_DIM  = C2_DIM,
  parameter int OUT_DIM = P2_DIM
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] conv2_maps [CH][IN_DIM][IN_DIM],
  output logic                     done,
  output logic signed [DATA_W-1:0] pool2_maps [CH][OUT_DIM][OUT_DIM],
`ifdef POOL2_STREAM_EN
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic [10:0]              out_idx,
`endif
  output pool_state_t              state
);

  // Handshake: start is a level, sampled only in IDLE; done rises after the
  // last pooled write and holds until the next accepted start; start must
  // fall after done before another run can be accepted.

  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
  localparam int RW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int YW    = RW + 1;
  localparam int IDX_W = CW + 2 * RW;

  localparam logic [CW-1:0] C_LAST = CW'(CH - 1);
  localparam logic [RW-1:0] D_LAST = RW'(OUT_DIM - 1);

  logic [CW-1:0] c_cnt;
  logic [RW-1:0] r_cnt;
  logic [RW-1:0] q_cnt;
  logic          drain_cnt;
  logic          last_idx;

  assign last_idx = (c_cnt == C_LAST) && (r_cnt == D_LAST) && (q_cnt == D_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      c_cnt     <= '0;
      r_cnt     <= '0;
      q_cnt     <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            c_cnt     <= '0;
            r_cnt     <= '0;
            q_cnt     <= '0;
            drain_cnt <= 1'b0;
            done      <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          // Counters return to zero on the final index so c never leaves range.
          if (last_idx) begin
            c_cnt <= '0;
            r_cnt <= '0;
            q_cnt <= '0;
            state <= DRAIN;
          end else if (q_cnt == D_LAST) begin
            q_cnt <= '0;
            if (r_cnt == D_LAST) begin
              r_cnt <= '0;
              c_cnt <= c_cnt + CW'(1);
            end else begin
              r_cnt <= r_cnt + RW'(1);
            end
          end else begin
            q_cnt <= q_cnt + RW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            drain_cnt <= 1'b0;
            state     <= DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= WAIT_START_LOW;
        end
        WAIT_START_LOW: begin
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [YW-1:0] y0, y1, x0, x1;
  assign y0 = {r_cnt, 1'b0};
  assign y1 = {r_cnt, 1'b1};
  assign x0 = {q_cnt, 1'b0};
  assign x1 = {q_cnt, 1'b1};

  logic                     res_valid;
  logic [IDX_W-1:0]         res_idx;
  logic signed [DATA_W-1:0] res_max;

  max4_pipe #(.IDX_W(IDX_W)) u_max4 (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (state == RUN),
    .issue_idx   ({c_cnt, r_cnt, q_cnt}),
    .px00        (conv2_maps[c_cnt][y0][x0]),
    .px01        (conv2_maps[c_cnt][y0][x1]),
    .px10        (conv2_maps[c_cnt][y1][x0]),
    .px11        (conv2_maps[c_cnt][y1][x1]),
    .res_valid   (res_valid),
    .res_idx     (res_idx),
    .res_max     (res_max)
  );

  logic [CW-1:0] rc;
  logic [RW-1:0] rr;
  logic [RW-1:0] rq;
  assign rc = res_idx[IDX_W-1 -: CW];
  assign rr = res_idx[2*RW-1 -: RW];
  assign rq = res_idx[RW-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++)
        for (int r = 0; r < OUT_DIM; r++)
          for (int q = 0; q < OUT_DIM; q++)
            pool2_maps[c][r][q] <= '0;
    end else if (res_valid) begin
      pool2_maps[rc][rr][rq] <= res_max;
    end
  end

`ifdef POOL2_STREAM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      out_valid <= res_valid;
      if (res_valid) begin
        out_data <= res_max;
        out_idx  <= 11'(int'(rc) * OUT_DIM * OUT_DIM + int'(rr) * OUT_DIM + int'(rq));
      end
    end
  end
`endif

endmodule

// File: tb/tb_pool2.sv
// Directed bench for pool2: reset, ramp/negative/extreme pooling, start-held,
// mid-run reset and (with POOL2_STREAM_EN) the result stream.
module tb_pool2;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic signed [31:0] in_maps [32][14][14];
  logic signed [31:0] maps [32][7][7];
  logic done;
  pool_state_t state;
`ifdef POOL2_STREAM_EN
  logic out_valid;
  logic signed [31:0] out_data;
  logic [10:0] out_idx;
`endif

  int checks = 0;
  int failures = 0;

  int done_cyc;
  logic done_at_1;
  pool_state_t state_at_1;
  bit stream_track = 0;
  int pulse_cnt, first_pulse, idx_err, data_err, state_err;
  logic [31:0] exp_q[$];

  pool2 dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .conv2_maps (in_maps),
    .done       (done),
    .pool2_maps (maps),
`ifdef POOL2_STREAM_EN
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_idx    (out_idx),
`endif
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic fill_ramp();
    for (int c = 0; c < 32; c++)
      for (int y = 0; y < 14; y++)
        for (int x = 0; x < 14; x++)
          in_maps[c][y][x] = c * 1000 + y * 14 + x;
  endtask

  task automatic fill_const(input logic signed [31:0] v);
    for (int c = 0; c < 32; c++)
      for (int y = 0; y < 14; y++)
        for (int x = 0; x < 14; x++)
          in_maps[c][y][x] = v;
  endtask

  // Raises start, counts cycles from acceptance (cycle 0) and stops when done
  // is first seen; done_cyc stays 0 if the budget runs out.
  task automatic run_job(input bit keep_start);
    int cyc;
    logic [31:0] e;
    pulse_cnt = 0; first_pulse = 0; idx_err = 0; data_err = 0; state_err = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    done_cyc = 0;
    done_at_1 = done;
    state_at_1 = state;
    if (!keep_start) start = 1'b0;
    while (cyc < 2500 && done_cyc == 0) begin
      if (done === 1'b1) done_cyc = cyc;
`ifdef POOL2_STREAM_EN
      if (stream_track && out_valid === 1'b1) begin
        if (pulse_cnt == 0) first_pulse = cyc;
        if (out_idx !== pulse_cnt[10:0]) idx_err++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (out_data !== e) data_err++;
        end else begin
          data_err++;
        end
        if (!(state == RUN || state == DRAIN)) state_err++;
        pulse_cnt++;
      end
`endif
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    int nz;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d want=%0d", state, IDLE);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b want=0", done);
    end
    nz = 0;
    foreach (maps[c, r, q]) if (maps[c][r][q] !== 32'sd0) nz++;
    checks++;
    if (nz !== 0) begin
      failures++;
      $display("FAIL reset_maps nonzero=%0d want=0", nz);
    end
`ifdef POOL2_STREAM_EN
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ramp();
    logic signed [31:0] exp;
    fill_ramp();
    run_job(0);
    checks++;
    if (done_at_1 !== 1'b0 || state_at_1 !== RUN) begin
      failures++;
      $display("FAIL ramp_cycle1 done=%b state=%0d want done=0 state=%0d", done_at_1, state_at_1, RUN);
    end
    checks++;
    if (done_cyc !== 1572) begin
      failures++;
      $display("FAIL ramp_done_cycle got=%0d want=1572", done_cyc);
    end
    for (int c = 0; c < 32; c++)
      for (int r = 0; r < 7; r++)
        for (int q = 0; q < 7; q++) begin
          exp = c * 1000 + (2 * r + 1) * 14 + 2 * q + 1;
          checks++;
          if (maps[c][r][q] !== exp) begin
            failures++;
            $display("FAIL ramp_map[%0d][%0d][%0d] got=%0d want=%0d", c, r, q, maps[c][r][q], exp);
          end
        end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_negative();
    logic signed [31:0] exp;
    fill_const(-32'sd100);
    in_maps[0][0][0] = -32'sd5;
    in_maps[0][0][1] = -32'sd3;
    in_maps[0][1][0] = -32'sd9;
    in_maps[0][1][1] = -32'sd7;
    run_job(0);
    checks++;
    if (done_cyc !== 1572) begin
      failures++;
      $display("FAIL neg_done_cycle got=%0d want=1572", done_cyc);
    end
    for (int c = 0; c < 32; c++)
      for (int r = 0; r < 7; r++)
        for (int q = 0; q < 7; q++) begin
          exp = (c == 0 && r == 0 && q == 0) ? -32'sd3 : -32'sd100;
          checks++;
          if (maps[c][r][q] !== exp) begin
            failures++;
            $display("FAIL neg_map[%0d][%0d][%0d] got=%0d want=%0d", c, r, q, maps[c][r][q], exp);
          end
        end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_extremes();
    logic signed [31:0] exp;
    fill_const(32'sh8000_0000);
    in_maps[31][13][13] = 32'sh7FFF_FFFF;
    run_job(0);
    checks++;
    if (done_cyc !== 1572) begin
      failures++;
      $display("FAIL ext_done_cycle got=%0d want=1572", done_cyc);
    end
    for (int c = 0; c < 32; c++)
      for (int r = 0; r < 7; r++)
        for (int q = 0; q < 7; q++) begin
          exp = (c == 31 && r == 6 && q == 6) ? 32'sh7FFF_FFFF : 32'sh8000_0000;
          checks++;
          if (maps[c][r][q] !== exp) begin
            failures++;
            $display("FAIL ext_map[%0d][%0d][%0d] got=%h want=%h", c, r, q, maps[c][r][q], exp);
          end
        end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_held();
    int low_cnt, rerun_cnt;
    fill_ramp();
    run_job(1);
    checks++;
    if (done_cyc !== 1572) begin
      failures++;
      $display("FAIL held_done_cycle got=%0d want=1572", done_cyc);
    end
    low_cnt = 0;
    rerun_cnt = 0;
    for (int i = done_cyc; i < 5000; i++) begin
      @(negedge clk);
      if (done !== 1'b1) low_cnt++;
      if (state == RUN) rerun_cnt++;
    end
    checks++;
    if (low_cnt !== 0) begin
      failures++;
      $display("FAIL held_done_low cycles=%0d want=0", low_cnt);
    end
    checks++;
    if (rerun_cnt !== 0) begin
      failures++;
      $display("FAIL held_retrigger run_cycles=%0d want=0", rerun_cnt);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== IDLE || done !== 1'b1) begin
      failures++;
      $display("FAIL held_release state=%0d done=%b want state=%0d done=1", state, done, IDLE);
    end
    run_job(0);
    checks++;
    if (done_at_1 !== 1'b0 || state_at_1 !== RUN) begin
      failures++;
      $display("FAIL rerun_cycle1 done=%b state=%0d want done=0 state=%0d", done_at_1, state_at_1, RUN);
    end
    checks++;
    if (done_cyc !== 1572) begin
      failures++;
      $display("FAIL rerun_done_cycle got=%0d want=1572", done_cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int nz, bad;
    fill_const(32'sd77);
    run_job(0);
    fill_ramp();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (799) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (state !== IDLE || done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_ctrl state=%0d done=%b want state=%0d done=0", state, done, IDLE);
    end
    nz = 0;
    foreach (maps[c, r, q]) if (maps[c][r][q] !== 32'sd0) nz++;
    checks++;
    if (nz !== 0) begin
      failures++;
      $display("FAIL midreset_maps nonzero=%0d want=0", nz);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_job(0);
    checks++;
    if (done_cyc !== 1572) begin
      failures++;
      $display("FAIL midreset_done_cycle got=%0d want=1572", done_cyc);
    end
    bad = 0;
    for (int c = 0; c < 32; c++)
      for (int r = 0; r < 7; r++)
        for (int q = 0; q < 7; q++)
          if (maps[c][r][q] !== 32'(c * 1000 + (2 * r + 1) * 14 + 2 * q + 1)) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL midreset_maps_rerun wrong_entries=%0d want=0", bad);
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef POOL2_STREAM_EN
  task automatic test_stream();
    exp_q.delete();
    for (int c = 0; c < 32; c++)
      for (int r = 0; r < 7; r++)
        for (int q = 0; q < 7; q++)
          exp_q.push_back(32'(c * 1000 + (2 * r + 1) * 14 + 2 * q + 1));
    fill_ramp();
    stream_track = 1;
    run_job(0);
    stream_track = 0;
    checks++;
    if (pulse_cnt !== 1568) begin
      failures++;
      $display("FAIL stream_pulses got=%0d want=1568", pulse_cnt);
    end
    checks++;
    if (first_pulse !== 3) begin
      failures++;
      $display("FAIL stream_first_pulse got=%0d want=3", first_pulse);
    end
    checks++;
    if (idx_err !== 0) begin
      failures++;
      $display("FAIL stream_idx_order errors=%0d want=0", idx_err);
    end
    checks++;
    if (data_err !== 0 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL stream_data errors=%0d leftover=%0d want=0/0", data_err, exp_q.size());
    end
    checks++;
    if (state_err !== 0) begin
      failures++;
      $display("FAIL stream_state pulses_outside_run_drain=%0d want=0", state_err);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_idle_valid got=%b want=0", out_valid);
    end
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    fill_const(32'sd0);
    test_reset();
    test_ramp();
    test_negative();
    test_extremes();
    test_start_held();
    test_reset_mid_run();
`ifdef POOL2_STREAM_EN
    test_stream();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
